// File: rtl/pacman_pkg.sv
// Shared types and default point values for the Pacman score path.
package pacman_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned DOT_PTS_DEF   = 1;
    localparam int unsigned POWER_PTS_DEF = 5;
    localparam int unsigned GHOST_PTS_DEF = 2;
    localparam int unsigned DOT_COUNT_DEF = 240;

    localparam int unsigned PENDING_MAX   = 255;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counter; carry is combinational so digits chain as a ripple counter.
module bcd_digit
    import pacman_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output bcd_t q,
    output logic carry
);

    bcd_t q_q;
    bcd_t q_d;

    assign q     = q_q;
    assign carry = inc && (q_q == 4'd9);

    // Next digit value: clear wins, otherwise increment with 9 -> 0 wrap.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Pacman score keeper: weights gameplay events into a pending pool, drains it
// one point per cycle into a saturating 3-digit BCD counter, frame-latches the
// digits for display and counts maze dots for level completion.
module score_keeper
    import pacman_pkg::*;
#(
    parameter int unsigned DOT_PTS   = DOT_PTS_DEF,
    parameter int unsigned POWER_PTS = POWER_PTS_DEF,
    parameter int unsigned GHOST_PTS = GHOST_PTS_DEF,
    parameter int unsigned DOT_COUNT = DOT_COUNT_DEF
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       frame,
    input  logic       clear,
    input  logic       pellet,
    input  logic       power,
    input  logic       ghost,
    output logic [3:0] score,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       busy,
    output logic       level_clear
);

    logic [7:0] pending_q, pending_d;
    logic [1:0] combo_q, combo_d;
    logic [7:0] dot_q, dot_d;
    logic       lvl_q, lvl_d;
    bcd_t       ones_disp_q, ones_disp_d;
    bcd_t       tens_disp_q, tens_disp_d;
    bcd_t       hund_disp_q, hund_disp_d;

    logic [9:0] weight;
    logic [9:0] sum;
    logic [7:0] dot_inc;
    logic       drain;
    logic       sat;
    logic       count_inc;

    bcd_t ones_w, tens_w, hund_w;
    logic ones_carry, tens_carry, hund_carry;

    assign sat       = (hund_w == 4'd9) && (tens_w == 4'd9) && (ones_w == 4'd9);
    // The pool always drains; once saturated the counter just stops advancing,
    // so excess points are silently discarded one per cycle.
    assign drain     = (pending_q != 8'd0);
    assign count_inc = drain && !sat && !clear;

    // Working counter: ones -> tens -> hundreds ripple chain.
    bcd_digit u_ones (
        .clk   (clk_pix),
        .rst   (rst_pix),
        .inc   (count_inc),
        .clr   (clear),
        .q     (ones_w),
        .carry (ones_carry)
    );

    bcd_digit u_tens (
        .clk   (clk_pix),
        .rst   (rst_pix),
        .inc   (ones_carry),
        .clr   (clear),
        .q     (tens_w),
        .carry (tens_carry)
    );

    bcd_digit u_hund (
        .clk   (clk_pix),
        .rst   (rst_pix),
        .inc   (tens_carry),
        .clr   (clear),
        .q     (hund_w),
        .carry (hund_carry)
    );

    // Event weight for this cycle; ghost uses the combo value before any update.
    always_comb begin
        weight = '0;
        if (pellet) weight = weight + 10'(DOT_PTS);
        if (power)  weight = weight + 10'(POWER_PTS);
        if (ghost)  weight = weight + (10'(GHOST_PTS) << combo_q);
    end

    // Pending pool, combo, dot counter and frame latch next-state.
    always_comb begin
        sum         = {2'b00, pending_q} - {9'd0, drain} + weight;
        dot_inc     = dot_q + 8'd1;
        pending_d   = (sum > 10'(PENDING_MAX)) ? 8'(PENDING_MAX) : sum[7:0];
        combo_d     = combo_q;
        dot_d       = dot_q;
        lvl_d       = 1'b0;
        ones_disp_d = ones_disp_q;
        tens_disp_d = tens_disp_q;
        hund_disp_d = hund_disp_q;

        if (power) begin
            combo_d = 2'd0;
        end else if (ghost && combo_q != 2'd3) begin
            combo_d = combo_q + 2'd1;
        end

        if (pellet || power) begin
            if (dot_inc == 8'(DOT_COUNT)) begin
                dot_d = '0;
                lvl_d = 1'b1;
            end else begin
                dot_d = dot_inc;
            end
        end

        if (frame) begin
            ones_disp_d = ones_w;
            tens_disp_d = tens_w;
            hund_disp_d = hund_w;
        end

        if (clear) begin
            pending_d   = '0;
            combo_d     = '0;
            dot_d       = '0;
            lvl_d       = 1'b0;
            ones_disp_d = '0;
            tens_disp_d = '0;
            hund_disp_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            pending_q   <= '0;
            combo_q     <= '0;
            dot_q       <= '0;
            lvl_q       <= 1'b0;
            ones_disp_q <= '0;
            tens_disp_q <= '0;
            hund_disp_q <= '0;
        end else begin
            pending_q   <= pending_d;
            combo_q     <= combo_d;
            dot_q       <= dot_d;
            lvl_q       <= lvl_d;
            ones_disp_q <= ones_disp_d;
            tens_disp_q <= tens_disp_d;
            hund_disp_q <= hund_disp_d;
        end
    end

    assign score       = ones_disp_q;
    assign tens        = tens_disp_q;
    assign hundreds    = hund_disp_q;
    assign busy        = (pending_q != 8'd0);
    assign level_clear = lvl_q;

    logic unused_carry;
    assign unused_carry = hund_carry;

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper (DOT_COUNT overridden to 4).
module tb_score_keeper;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic       frame   = 1'b0;
    logic       clear   = 1'b0;
    logic       pellet  = 1'b0;
    logic       power   = 1'b0;
    logic       ghost   = 1'b0;
    logic [3:0] score, tens, hundreds;
    logic       busy, level_clear;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk_pix = ~clk_pix;

    score_keeper #(.DOT_COUNT(4)) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .frame       (frame),
        .clear       (clear),
        .pellet      (pellet),
        .power       (power),
        .ghost       (ghost),
        .score       (score),
        .tens        (tens),
        .hundreds    (hundreds),
        .busy        (busy),
        .level_clear (level_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        step();
        frame = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b0) break;
            step();
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_disp(input string tag, input int h, input int t, input int o);
        chk({tag, "_hund"}, {28'd0, hundreds}, h);
        chk({tag, "_tens"}, {28'd0, tens}, t);
        chk({tag, "_ones"}, {28'd0, score}, o);
    endtask

    initial begin
        // Reset values
        #2;
        chk_disp("rst", 0, 0, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_lvl", {31'd0, level_clear}, 0);
        rst_pix = 1'b0;

        // Three consecutive pellets
        pellet = 1'b1;
        step();
        chk("pel_busy_t1", {31'd0, busy}, 1);
        step();
        step();
        pellet = 1'b0;
        step();
        chk("pel_busy_t4", {31'd0, busy}, 0);
        repeat (6) step();
        pulse_frame();
        chk_disp("pel3", 0, 0, 3);

        // Fourth dot (power) completes the level, then reset mid-drain
        power = 1'b1;
        step();
        power = 1'b0;
        chk("pwr_lvl", {31'd0, level_clear}, 1);
        step();
        chk("pwr_lvl_drop", {31'd0, level_clear}, 0);
        #2;
        rst_pix = 1'b1;
        #1;
        chk_disp("async_rst", 0, 0, 0);
        chk("async_rst_busy", {31'd0, busy}, 0);
        rst_pix = 1'b0;
        step();
        pulse_frame();
        chk_disp("post_rst", 0, 0, 0);

        // Ghost combo: 5 + 2 + 4 + 8 + 16 + 16 = 51
        power = 1'b1;
        step();
        power = 1'b0;
        ghost = 1'b1;
        repeat (5) step();
        ghost = 1'b0;
        wait_idle("combo_idle");
        pulse_frame();
        chk_disp("combo", 0, 5, 1);

        do_clear();
        chk_disp("clear", 0, 0, 0);
        chk("clear_busy", {31'd0, busy}, 0);

        // Simultaneous events weigh 8, combo restarts so the next ghost is 2
        pellet = 1'b1; power = 1'b1; ghost = 1'b1;
        step();
        pellet = 1'b0; power = 1'b0;
        step();
        ghost = 1'b0;
        wait_idle("simul_idle");
        pulse_frame();
        chk_disp("simul", 0, 1, 0);

        // Level clear with DOT_COUNT = 4
        do_clear();
        pellet = 1'b1;
        repeat (3) step();
        pellet = 1'b0;
        chk("lvl_early", {31'd0, level_clear}, 0);
        power = 1'b1;
        step();
        power = 1'b0;
        chk("lvl_pulse", {31'd0, level_clear}, 1);
        step();
        chk("lvl_single", {31'd0, level_clear}, 0);
        pellet = 1'b1;
        repeat (3) step();
        chk("lvl_cnt_reset", {31'd0, level_clear}, 0);
        step();
        pellet = 1'b0;
        chk("lvl_again", {31'd0, level_clear}, 1);
        wait_idle("lvl_idle");
        pulse_frame();
        chk_disp("lvl_score", 0, 1, 2);

        // Clear beats ghost, and frame with clear zeroes outputs
        clear = 1'b1; ghost = 1'b1; frame = 1'b1;
        step();
        clear = 1'b0; ghost = 1'b0; frame = 1'b0;
        chk("clr_ghost_busy", {31'd0, busy}, 0);
        chk_disp("clr_frame", 0, 0, 0);
        step();
        chk("clr_ghost_busy2", {31'd0, busy}, 0);
        pulse_frame();
        chk_disp("clr_ghost", 0, 0, 0);

        // Frame mid-drain shows the partial (pre-increment) count
        power = 1'b1;
        step();
        power = 1'b0;
        step();
        step();
        pulse_frame();
        chk_disp("mid_drain", 0, 0, 2);
        wait_idle("mid_idle");
        pulse_frame();
        chk_disp("mid_final", 0, 0, 5);

        // Saturation: preload 995 via spaced power pellets, then add 20
        do_clear();
        for (int i = 0; i < 199; i++) begin
            power = 1'b1;
            step();
            power = 1'b0;
            repeat (4) step();
        end
        wait_idle("pre_idle");
        pulse_frame();
        chk_disp("preload", 9, 9, 5);
        power = 1'b1;
        repeat (4) step();
        power = 1'b0;
        wait_idle("sat_idle");
        pulse_frame();
        chk_disp("sat", 9, 9, 9);
        pellet = 1'b1;
        step();
        pellet = 1'b0;
        chk("sat_busy", {31'd0, busy}, 1);
        wait_idle("sat_idle2");
        pulse_frame();
        chk_disp("sat_hold", 9, 9, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
